// File: rtl/dsp_dual_acc_pkg.sv
// Shared DSP constants and FSM type for the dual-lane accumulator.
// Holds default widths and the controller state enum.
package dsp_dual_acc_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_QUANT = 2'd2,
    ST_HOLD  = 2'd3
  } acc_state_e;

endpackage

// File: rtl/dsp_dual_acc_if.sv
// Product-beat / result bundle between multiplier, accumulator, consumer.
// master drives beats and takes results; slave is the accumulator side.
interface dsp_dual_acc_if #(
  parameter int LEN_W = dsp_dual_acc_pkg::LEN_W_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [15:0]      in_ac;
  logic signed [15:0]      in_bc;
  logic        [LEN_W-1:0] cfg_len;
  logic        [4:0]       cfg_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [7:0]       out_ac;
  logic signed [7:0]       out_bc;
  logic                    ovf_sticky;

  modport master (
    output in_valid, in_ac, in_bc,
    output cfg_len, cfg_shift, out_ready,
    input  in_ready, out_valid,
    input  out_ac, out_bc, ovf_sticky
  );

  modport slave (
    input  in_valid, in_ac, in_bc,
    input  cfg_len, cfg_shift, out_ready,
    output in_ready, out_valid,
    output out_ac, out_bc, ovf_sticky
  );

endinterface

// File: rtl/dsp_requant.sv
// Round-half-up, arithmetic right shift and saturate to signed 8 bits.
// Ports: acc_i (ACC_W signed), shift_i (0..31), res_o (signed 8).
module dsp_requant
  import dsp_dual_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [4:0]       shift_i,
  output logic signed [7:0]       res_o
);

  // Wide enough for acc plus a 2^30 rounding term without overflow.
  localparam int EW = (ACC_W > 32 ? ACC_W : 32) + 2;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] shr;
  logic        [EW-8:0] upper;

  always_comb begin
    ext = {{(EW-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    rnd = '0;
    if (shift_i != 5'd0) begin
      rnd[shift_i - 5'd1] = 1'b1;
    end
    sum   = ext + rnd;
    shr   = sum >>> shift_i;
    upper = shr[EW-1:7];
    // In range only when bits above bit 7 are pure sign extension.
    if (upper == '0 || upper == '1) begin
      res_o = shr[7:0];
    end else if (shr[EW-1]) begin
      res_o = 8'sh80;
    end else begin
      res_o = 8'sh7f;
    end
  end

endmodule

// File: rtl/dsp_dual_acc.sv
// Dual-lane saturating dot-product accumulator with requantised output.
// Beats in_ac/in_bc summed cfg_len times, shifted by cfg_shift, held.
module dsp_dual_acc
  import dsp_dual_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_ac,
  input  logic signed [15:0]      in_bc,
  input  logic        [LEN_W-1:0] cfg_len,
  input  logic        [4:0]       cfg_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [7:0]       out_ac,
  output logic signed [7:0]       out_bc,
  output logic                    ovf_sticky
);

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  acc_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_ac_q, acc_ac_d;
  logic signed [ACC_W-1:0] acc_bc_q, acc_bc_d;
  logic        [LEN_W-1:0] cnt_q, cnt_d;
  logic        [LEN_W-1:0] len_q, len_d;
  logic        [4:0]       shift_q, shift_d;
  logic signed [7:0]       out_ac_q, out_ac_d;
  logic signed [7:0]       out_bc_q, out_bc_d;
  logic                    ovf_q, ovf_d;
  logic                    rdy_q;

  logic signed [ACC_W-1:0] ext_ac, ext_bc;
  logic signed [ACC_W:0]   sum_ac, sum_bc;
  logic signed [ACC_W-1:0] sat_ac, sat_bc;
  logic                    ovf_ac, ovf_bc;
  logic signed [7:0]       rq_ac, rq_bc;
  logic                    take;
  logic        [LEN_W-1:0] len_eff;

  dsp_requant #(.ACC_W(ACC_W)) u_rq_ac (
    .acc_i   (acc_ac_q),
    .shift_i (shift_q),
    .res_o   (rq_ac)
  );

  dsp_requant #(.ACC_W(ACC_W)) u_rq_bc (
    .acc_i   (acc_bc_q),
    .shift_i (shift_q),
    .res_o   (rq_bc)
  );

  // rdy_q keeps in_ready low through reset and up at the first edge.
  assign in_ready   = rdy_q &&
                      (state_q == ST_IDLE || state_q == ST_ACCUM);
  assign take       = in_valid && in_ready;
  assign out_valid  = (state_q == ST_HOLD);
  assign out_ac     = out_ac_q;
  assign out_bc     = out_bc_q;
  assign ovf_sticky = ovf_q;

  always_comb begin
    ext_ac = {{(ACC_W-16){in_ac[15]}}, in_ac};
    ext_bc = {{(ACC_W-16){in_bc[15]}}, in_bc};
    sum_ac = {acc_ac_q[ACC_W-1], acc_ac_q} + {ext_ac[ACC_W-1], ext_ac};
    sum_bc = {acc_bc_q[ACC_W-1], acc_bc_q} + {ext_bc[ACC_W-1], ext_bc};
    ovf_ac = sum_ac[ACC_W] != sum_ac[ACC_W-1];
    ovf_bc = sum_bc[ACC_W] != sum_bc[ACC_W-1];
    sat_ac = ovf_ac ? (sum_ac[ACC_W] ? ACC_MIN : ACC_MAX)
                    : sum_ac[ACC_W-1:0];
    sat_bc = ovf_bc ? (sum_bc[ACC_W] ? ACC_MIN : ACC_MAX)
                    : sum_bc[ACC_W-1:0];
    len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  end

  always_comb begin
    state_d  = state_q;
    acc_ac_d = acc_ac_q;
    acc_bc_d = acc_bc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    shift_d  = shift_q;
    out_ac_d = out_ac_q;
    out_bc_d = out_bc_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          len_d    = len_eff;
          shift_d  = cfg_shift;
          acc_ac_d = ext_ac;
          acc_bc_d = ext_bc;
          cnt_d    = LEN_W'(1);
          state_d  = (len_eff == LEN_W'(1)) ? ST_QUANT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (take) begin
          acc_ac_d = sat_ac;
          acc_bc_d = sat_bc;
          ovf_d    = ovf_q | ovf_ac | ovf_bc;
          cnt_d    = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d = ST_QUANT;
          end
        end
      end
      ST_QUANT: begin
        out_ac_d = rq_ac;
        out_bc_d = rq_bc;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_ac_q <= '0;
      acc_bc_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      shift_q  <= '0;
      out_ac_q <= '0;
      out_bc_q <= '0;
      ovf_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_ac_q <= acc_ac_d;
      acc_bc_q <= acc_bc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      shift_q  <= shift_d;
      out_ac_q <= out_ac_d;
      out_bc_q <= out_bc_d;
      ovf_q    <= ovf_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dsp_dual_acc.sv
// Directed self-checking bench for dsp_dual_acc.
// Hand-computed vectors cover rounding, saturation, backpressure, reset.
module tb_dsp_dual_acc;
  import dsp_dual_acc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  dsp_dual_acc_if #(.LEN_W(LEN_W_DEF)) u_if ();

  dsp_dual_acc u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (u_if.in_valid),
    .in_ready   (u_if.in_ready),
    .in_ac      (u_if.in_ac),
    .in_bc      (u_if.in_bc),
    .cfg_len    (u_if.cfg_len),
    .cfg_shift  (u_if.cfg_shift),
    .out_valid  (u_if.out_valid),
    .out_ready  (u_if.out_ready),
    .out_ac     (u_if.out_ac),
    .out_bc     (u_if.out_bc),
    .ovf_sticky (u_if.ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (u_if.in_ready) break;
      @(posedge clk); #1;
    end
    chk("ready_wait", 32'(u_if.in_ready), 1);
  endtask

  // Streams back-to-back beats, scrambling cfg after the first one,
  // then checks out_valid is low in QUANT and high one cycle later.
  task automatic run(input int len, input int shift,
                     input int ac, input int bc);
    int n;
    n = (len == 0) ? 1 : len;
    wait_ready();
    u_if.cfg_len   = LEN_W_DEF'(len);
    u_if.cfg_shift = 5'(shift);
    u_if.in_ac     = 16'(ac);
    u_if.in_bc     = 16'(bc);
    u_if.in_valid  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      u_if.cfg_len   = '0;
      u_if.cfg_shift = 5'd7;
    end
    u_if.in_valid = 1'b0;
    chk("valid_in_quant", 32'(u_if.out_valid), 0);
    chk("ready_in_quant", 32'(u_if.in_ready), 0);
    @(posedge clk); #1;
    chk("valid_2cyc", 32'(u_if.out_valid), 1);
  endtask

  task automatic take_result();
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    chk("idle_valid", 32'(u_if.out_valid), 0);
    chk("idle_ready", 32'(u_if.in_ready), 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_ac     = '0;
    u_if.in_bc     = '0;
    u_if.cfg_len   = '0;
    u_if.cfg_shift = '0;
    u_if.out_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(u_if.in_ready), 0);
    chk("rst_valid", 32'(u_if.out_valid), 0);
    chk("rst_ac", 32'(u_if.out_ac), 0);
    chk("rst_ovf", 32'(u_if.ovf_sticky), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_ready", 32'(u_if.in_ready), 1);

    // 4 x 100 = 400 -> (400+2)>>2 = 100; 4 x -50 -> (-198)>>>2 = -50
    run(4, 2, 100, -50);
    chk("t1_ac", 32'(u_if.out_ac), 100);
    chk("t1_bc", 32'(u_if.out_bc), -50);
    take_result();

    // 131068 -> 127, -131072 -> -128, no accumulator saturation
    run(4, 0, 32767, -32768);
    chk("t3_ac", 32'(u_if.out_ac), 127);
    chk("t3_bc", 32'(u_if.out_bc), -128);
    chk("t3_ovf", 32'(u_if.ovf_sticky), 0);
    take_result();

    // len 0 acts as 1: (3+1)>>1 = 2, (-3+1)>>>1 = -1
    run(0, 1, 3, -3);
    chk("t5_ac", 32'(u_if.out_ac), 2);
    chk("t5_bc", 32'(u_if.out_bc), -1);
    take_result();

    // Backpressure: 5 cycles held with beats offered
    run(4, 2, 100, -50);
    u_if.in_ac    = 16'sd1000;
    u_if.in_bc    = 16'sd1000;
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(u_if.out_valid), 1);
      chk("hold_ready", 32'(u_if.in_ready), 0);
      chk("hold_ac", 32'(u_if.out_ac), 100);
      chk("hold_bc", 32'(u_if.out_bc), -50);
    end
    u_if.in_valid = 1'b0;
    take_result();

    // 300 x 32767 saturates at 2^23-1; (8388607+32768)>>16 -> 127
    run(300, 16, 32767, -1);
    chk("t2_acc", 32'(u_dut.acc_ac_q), 8388607);
    chk("t2_ovf", 32'(u_if.ovf_sticky), 1);
    chk("t2_ac", 32'(u_if.out_ac), 127);
    chk("t2_bc", 32'(u_if.out_bc), 0);
    take_result();

    // Reset after 2 of 4 beats
    wait_ready();
    u_if.cfg_len   = LEN_W_DEF'(4);
    u_if.cfg_shift = 5'd0;
    u_if.in_ac     = 16'sd50;
    u_if.in_bc     = 16'sd50;
    u_if.in_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    u_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(u_if.in_ready), 0);
    chk("mid_rst_valid", 32'(u_if.out_valid), 0);
    chk("mid_rst_ac", 32'(u_if.out_ac), 0);
    chk("mid_rst_bc", 32'(u_if.out_bc), 0);
    chk("mid_rst_ovf", 32'(u_if.ovf_sticky), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(u_if.in_ready), 1);
    // 4 x 1 = 4, 4 x -1 = -4
    run(4, 0, 1, -1);
    chk("t6_ac", 32'(u_if.out_ac), 4);
    chk("t6_bc", 32'(u_if.out_bc), -4);
    chk("t6_ovf", 32'(u_if.ovf_sticky), 0);
    take_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
